// File: rtl/mux4_arb_pkg.sv
// Shared constants for the four-way round-robin arbiter: slot states, requester
// indices and the pointer reset value.
package mux4_arb_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam logic [1:0] REQ1 = 2'd0;
  localparam logic [1:0] REQ2 = 2'd1;
  localparam logic [1:0] REQ3 = 2'd2;
  localparam logic [1:0] REQ4 = 2'd3;

  // Pointer starts on the last requester so in1 holds first priority.
  localparam logic [1:0] PTR_RST = REQ4;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: grants the first set request after ptr,
// searching ptr+1, ptr+2, ptr+3, ptr (mod 4).
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt,
  output logic [1:0] idx
);

  logic [1:0] cand [4];
  logic [3:0] rot;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rot
      assign cand[gi] = ptr + 2'(gi + 1);
      assign rot[gi]  = req[cand[gi]];
    end
  endgenerate

  // Walk from the farthest candidate down so the nearest one wins.
  always_comb begin
    gnt = 4'b0000;
    idx = REQ1;
    for (int k = 3; k >= 0; k--) begin
      if (rot[k]) begin
        gnt = 4'b0001 << cand[k];
        idx = cand[k];
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Four-requester round-robin arbiter feeding a one-entry registered output slot.
// Define MUX4_ARB_LOCK_EN to add lck1..lck4 and locked (exclusive) bursts.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int Width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] in1,
  input  logic [Width-1:0] in2,
  input  logic [Width-1:0] in3,
  input  logic [Width-1:0] in4,
  input  logic             vld1,
  input  logic             vld2,
  input  logic             vld3,
  input  logic             vld4,
  output logic             rdy1,
  output logic             rdy2,
  output logic             rdy3,
  output logic             rdy4,
`ifdef MUX4_ARB_LOCK_EN
  input  logic             lck1,
  input  logic             lck2,
  input  logic             lck3,
  input  logic             lck4,
`endif
  output logic [Width-1:0] ou1,
  output logic             ou1_vld,
  input  logic             ou1_rdy,
  output logic [1:0]       sel
);

  state_t           state_reg, state_next;
  logic [Width-1:0] ou1_reg;
  logic [1:0]       sel_reg, ptr_reg;
  logic [Width-1:0] in_arr [4];
  logic [3:0]       vld_vec, req_vec, pick_gnt, gnt;
  logic [1:0]       pick_idx;
  logic             xfer;

  assign in_arr[0] = in1;
  assign in_arr[1] = in2;
  assign in_arr[2] = in3;
  assign in_arr[3] = in4;
  assign vld_vec   = {vld4, vld3, vld2, vld1};

`ifdef MUX4_ARB_LOCK_EN
  logic       lock_reg;
  logic [1:0] lock_idx_reg;
  logic [3:0] lck_vec;

  assign lck_vec = {lck4, lck3, lck2, lck1};
  // While locked only the owner may compete, even if it is idle.
  assign req_vec = lock_reg ? (vld_vec & (4'b0001 << lock_idx_reg)) : vld_vec;

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_reg     <= 1'b0;
      lock_idx_reg <= REQ1;
    end else if (xfer) begin
      lock_reg     <= lck_vec[pick_idx];
      lock_idx_reg <= pick_idx;
    end
  end
`else
  assign req_vec = vld_vec;
`endif

  rr_pick4 u_pick (
    .req (req_vec),
    .ptr (ptr_reg),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_EMPTY;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    gnt        = 4'b0000;
    case (state_reg)
      ST_EMPTY: begin
        if (!rst && |pick_gnt) begin
          gnt        = pick_gnt;
          state_next = ST_FULL;
        end
      end
      ST_FULL: begin
        if (!rst && ou1_rdy) begin
          if (|pick_gnt) gnt        = pick_gnt;
          else           state_next = ST_EMPTY;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
    xfer = |gnt;
  end

  // ou1/sel keep their last value after a drain; only a new beat or reset moves them.
  always_ff @(posedge clk) begin
    if (rst) begin
      ou1_reg <= '0;
      sel_reg <= REQ1;
      ptr_reg <= PTR_RST;
    end else if (xfer) begin
      ou1_reg <= in_arr[pick_idx];
      sel_reg <= pick_idx;
      ptr_reg <= pick_idx;
    end
  end

  assign rdy1    = gnt[0];
  assign rdy2    = gnt[1];
  assign rdy3    = gnt[2];
  assign rdy4    = gnt[3];
  assign ou1     = ou1_reg;
  assign ou1_vld = (state_reg == ST_FULL);
  assign sel     = sel_reg;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed scenarios plus random traffic
// against a behavioural slot/priority model.
module tb_mux4_rr_arbiter;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  in_w [4];
  logic [3:0]    vld;
  logic          ou1_rdy;
  logic          rdy1, rdy2, rdy3, rdy4;
  logic [3:0]    rdy;
  logic [W-1:0]  ou1;
  logic          ou1_vld;
  logic [1:0]    sel;
`ifdef MUX4_ARB_LOCK_EN
  logic [3:0]    lck;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: slot contents, last granted requester, lock owner.
  bit           m_full  = 0;
  logic [W-1:0] m_word  = '0;
  int           m_sel   = 0;
  int           m_last  = 3;
  bit           m_lock  = 0;
  int           m_owner = 0;

  always #5 clk = ~clk;
  assign rdy = {rdy4, rdy3, rdy2, rdy1};

  mux4_rr_arbiter #(.Width(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .in1     (in_w[0]),
    .in2     (in_w[1]),
    .in3     (in_w[2]),
    .in4     (in_w[3]),
    .vld1    (vld[0]),
    .vld2    (vld[1]),
    .vld3    (vld[2]),
    .vld4    (vld[3]),
    .rdy1    (rdy1),
    .rdy2    (rdy2),
    .rdy3    (rdy3),
    .rdy4    (rdy4),
`ifdef MUX4_ARB_LOCK_EN
    .lck1    (lck[0]),
    .lck2    (lck[1]),
    .lck3    (lck[2]),
    .lck4    (lck[3]),
`endif
    .ou1     (ou1),
    .ou1_vld (ou1_vld),
    .ou1_rdy (ou1_rdy),
    .sel     (sel)
  );

  // Winner per the rules: slot must be able to take a word, then the first valid
  // requester after the last grant; a held lock admits only its owner.
  function automatic int winner();
    if (rst) return -1;
    if (m_full && !ou1_rdy) return -1;
    for (int k = 1; k <= 4; k++) begin
      int r;
      r = (m_last + k) % 4;
      if (vld[r] && (!m_lock || r == m_owner)) return r;
    end
    return -1;
  endfunction

  // One clock: check combinational rdy, take the edge, update model, check outputs.
  task automatic cycle(input string name);
    int         w;
    logic [3:0] exp_rdy;
    #1;
    w       = winner();
    exp_rdy = (w >= 0) ? (4'b0001 << w) : 4'b0000;
    checks++;
    if (rdy !== exp_rdy) begin
      errors++;
      $display("FAIL %s rdy got=%b exp=%b", name, rdy, exp_rdy);
    end
    @(posedge clk);
    if (rst) begin
      m_full = 0; m_word = '0; m_sel = 0; m_last = 3; m_lock = 0; m_owner = 0;
    end else if (w >= 0) begin
      m_full = 1; m_word = in_w[w]; m_sel = w; m_last = w;
`ifdef MUX4_ARB_LOCK_EN
      m_lock = lck[w]; m_owner = w;
`endif
    end else if (m_full && ou1_rdy) begin
      m_full = 0;
    end
    #1;
    checks++;
    if ({ou1_vld, sel, ou1} !== {m_full, 2'(m_sel), m_word}) begin
      errors++;
      $display("FAIL %s out got vld=%b sel=%0d ou1=%h exp vld=%b sel=%0d ou1=%h",
               name, ou1_vld, sel, ou1, m_full, m_sel, m_word);
    end
    $display("%s t=%0t vld=%b rdy=%b ou1_rdy=%b -> ou1_vld=%b sel=%0d ou1=%h",
             name, $time, vld, exp_rdy, ou1_rdy, ou1_vld, sel, ou1);
  endtask

  task automatic idle_inputs();
    vld     = 4'b0000;
    ou1_rdy = 1'b1;
`ifdef MUX4_ARB_LOCK_EN
    lck     = 4'b0000;
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle("rst");
    rst = 1'b0;
  endtask

  task automatic test_reset();
    vld = 4'b1111; ou1_rdy = 1'b1;
    rst = 1'b1;
    cycle("reset");
    checks++;
    if (ou1 !== '0 || ou1_vld !== 1'b0 || sel !== 2'd0) begin
      errors++;
      $display("FAIL reset_state got ou1=%h vld=%b sel=%0d exp 0/0/0", ou1, ou1_vld, sel);
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_single();
    do_reset();
    in_w[2] = 32'hA5A5_A5A5; vld = 4'b0100; ou1_rdy = 1'b1;
    cycle("single");
    checks++;
    if (ou1 !== 32'hA5A5_A5A5 || sel !== 2'd2 || ou1_vld !== 1'b1) begin
      errors++;
      $display("FAIL single got ou1=%h sel=%0d vld=%b exp a5a5a5a5/2/1", ou1, sel, ou1_vld);
    end
    idle_inputs();
  endtask

  task automatic test_rotate();
    do_reset();
    for (int r = 0; r < 4; r++) in_w[r] = W'(r + 1);
    vld = 4'b1111; ou1_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle("rotate");
      checks++;
      if (ou1 !== W'(i % 4 + 1) || sel !== 2'(i % 4) || ou1_vld !== 1'b1) begin
        errors++;
        $display("FAIL rotate beat %0d got ou1=%h sel=%0d vld=%b exp %0d/%0d/1",
                 i, ou1, sel, ou1_vld, i % 4 + 1, i % 4);
      end
    end
    idle_inputs();
  endtask

  task automatic test_stall();
    do_reset();
    in_w[0] = 32'h11; vld = 4'b0001; ou1_rdy = 1'b1;
    cycle("stall_fill");
    in_w[1] = 32'h22; vld = 4'b0010; ou1_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle("stall");
      checks++;
      if (ou1 !== 32'h11 || ou1_vld !== 1'b1 || rdy2 !== 1'b0) begin
        errors++;
        $display("FAIL stall hold got ou1=%h vld=%b rdy2=%b exp 11/1/0", ou1, ou1_vld, rdy2);
      end
    end
    ou1_rdy = 1'b1;
    cycle("stall_release");
    checks++;
    if (ou1 !== 32'h22 || sel !== 2'd1) begin
      errors++;
      $display("FAIL stall_release got ou1=%h sel=%0d exp 22/1", ou1, sel);
    end
    vld = 4'b0000;
    cycle("drain");
    checks++;
    if (ou1_vld !== 1'b0) begin
      errors++;
      $display("FAIL drain got ou1_vld=%b exp 0", ou1_vld);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    in_w[0] = 32'h33; vld = 4'b0001; ou1_rdy = 1'b1;
    cycle("mid_fill");
    ou1_rdy = 1'b0;
    cycle("mid_stall");
    rst = 1'b1;
    cycle("mid_rst");
    checks++;
    if (ou1 !== '0 || ou1_vld !== 1'b0 || sel !== 2'd0) begin
      errors++;
      $display("FAIL mid_rst got ou1=%h vld=%b sel=%0d exp 0/0/0", ou1, ou1_vld, sel);
    end
    rst = 1'b0;
    in_w[3] = 32'h44; vld = 4'b1001; ou1_rdy = 1'b1;
    cycle("mid_after");
    checks++;
    if (ou1 !== 32'h33 || sel !== 2'd0) begin
      errors++;
      $display("FAIL mid_after got ou1=%h sel=%0d exp 33/0", ou1, sel);
    end
    idle_inputs();
  endtask

`ifdef MUX4_ARB_LOCK_EN
  task automatic test_lock();
    int exp_sel [4];
    exp_sel = '{1, 1, 1, 2};
    do_reset();
    for (int r = 0; r < 4; r++) in_w[r] = W'(32'h100 + r);
    vld = 4'b0001; ou1_rdy = 1'b1;
    cycle("lock_pre");
    vld = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      lck = (i < 2) ? 4'b0010 : 4'b0000;
      cycle("lock");
      checks++;
      if (sel !== 2'(exp_sel[i])) begin
        errors++;
        $display("FAIL lock beat %0d got sel=%0d exp %0d", i, sel, exp_sel[i]);
      end
    end
    idle_inputs();
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      for (int r = 0; r < 4; r++) in_w[r] = $urandom;
      vld     = 4'($urandom);
      ou1_rdy = ($urandom_range(0, 3) != 0);
      rst     = ($urandom_range(0, 49) == 0);
`ifdef MUX4_ARB_LOCK_EN
      lck     = 4'($urandom) & 4'($urandom);
`endif
      cycle("random");
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    for (int r = 0; r < 4; r++) in_w[r] = '0;
    idle_inputs();
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_rotate();
    test_stall();
    test_reset_mid();
`ifdef MUX4_ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
